// File: rtl/ipu_pkg.sv
// Shared types and defaults for the instruction prefetch unit.
package ipu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int NPC_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD,
    ST_HALTED
  } ipu_state_t;

  // Instruction width is fixed here; the top's DATA_W must match it.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [NPC_W-1:0]      npc;
  } ipu_entry_t;

endpackage

// File: rtl/ipu_fifo.sv
// Fetch queue: synchronous FIFO with flush, occupancy count and registered head.
module ipu_fifo
  import ipu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  ipu_entry_t             push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output ipu_entry_t             head
);

  localparam int PTR_W = $clog2(DEPTH);

  ipu_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [PTR_W:0]         count_nxt;
  logic                   do_pop;

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    do_pop     = pop && head_valid;
    rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
    count_nxt  = count + (PTR_W+1)'(push) - (PTR_W+1)'(do_pop);
  end

  // NOTE: the storage array is not reset; count and head_valid already mark it empty.
  always_ff @(posedge clk1) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr + PTR_W'(push);
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      // A push into an otherwise empty queue bypasses the array straight to the head.
      if (push && rd_ptr_nxt == wr_ptr) head <= push_data;
      else if (count_nxt != '0)         head <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch front end: issues word reads over req/ack, queues {instr, npc} for decode,
// flushes on taken branches and stops issuing while halted.
module instr_prefetch_unit
  import ipu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ifq_valid,
  output logic [DATA_W-1:0] ifq_instr,
  output logic [31:0]       ifq_npc,
  input  logic              ifq_ready
);

  ipu_state_t            state;
  logic [ADDR_W-1:0]     pc, ack_npc;
  logic [$clog2(DEPTH):0] count;
  logic                  inflight, can_issue, push;
  ipu_entry_t            push_data, head;

  // Credit uses the current count only; a same-cycle pop frees its slot a cycle later.
  always_comb begin
    inflight        = (state == ST_WAIT);
    can_issue       = !halt && ((int'(count) + int'(inflight)) < DEPTH);
    ack_npc         = mem_addr + ADDR_W'(1);
    push            = inflight && mem_ack && !redirect_valid;
    push_data.instr = mem_rdata;
    push_data.npc   = NPC_W'(ack_npc);
  end

  // NOTE: non-blocking assignments throughout; a later pc update in the case below
  // overrides the redirect load only on paths where no redirect is present.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      case (state)
        ST_IDLE: begin
          if (!redirect_valid) begin
            if (halt) begin
              state <= ST_HALTED;
            end else if (can_issue) begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              pc       <= pc + ADDR_W'(1);
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            // Without an ack the request must stay up until memory completes it.
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              state <= ST_DISCARD;
            end
          end else if (mem_ack) begin
            if (can_issue) begin
              mem_addr <= pc;
              pc       <= pc + ADDR_W'(1);
            end else begin
              mem_req <= 1'b0;
              state   <= halt ? ST_HALTED : ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          if (!halt) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ipu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (ifq_ready),
    .count     (count),
    .head_valid(ifq_valid),
    .head      (head)
  );

  assign ifq_instr = head.instr;
  assign ifq_npc   = head.npc;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench: memory/branch stimulus feeds a fetch-stream model; a monitor checks decode output.
module tb_instr_prefetch_unit;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef struct packed { logic [31:0] instr; logic [31:0] npc; } exp_t;
  typedef enum int {TRG_NONE, TRG_NOW, TRG_ON_ACK, TRG_ON_NEW} trg_t;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              ifq_valid;
  logic [DATA_W-1:0] ifq_instr;
  logic [31:0]       ifq_npc;
  logic              ifq_ready;

  instr_prefetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk1          (clk1),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ifq_valid     (ifq_valid),
    .ifq_instr     (ifq_instr),
    .ifq_npc       (ifq_npc),
    .ifq_ready     (ifq_ready)
  );

  always #5 clk1 = ~clk1;

  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  exp_t exp_q[$];
  bit   mon_en = 0;

  // Reference model: the fetch address stream, an epoch that invalidates requests
  // overtaken by a redirect, and one-cycle-delayed queue updates.
  logic [ADDR_W-1:0] fetch_pc, req_addr_m, trg_pc;
  bit   req_active, new_req, pend_valid, flush_pend, prev_halt, prev_redirect, halt_force;
  int   epoch, req_epoch, wait_left;
  int   lat_min, lat_max, ready_pct, halt_pct, redir_pct;
  exp_t pend;
  trg_t trg;

  function automatic logic [31:0] mem_word(logic [ADDR_W-1:0] a);
    return 32'(a) + 32'h100;
  endfunction

  function automatic logic [31:0] npc_of(logic [ADDR_W-1:0] a);
    return (32'(a) + 32'd1) % (32'd1 << ADDR_W);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fetch_pc = '0; req_addr_m = '0; req_active = 0; new_req = 0;
    pend_valid = 0; flush_pend = 0; prev_halt = 0; prev_redirect = 0;
    epoch = 0; req_epoch = 0; wait_left = 0; trg = TRG_NONE; trg_pc = '0;
    lat_min = 0; lat_max = 0; ready_pct = 100; halt_pct = 0; redir_pct = 0; halt_force = 0;
  endtask

  // One clock of stimulus: drive at posedge+1 and advance the model.
  task automatic cycle();
    bit ack_now;
    @(posedge clk1); #1;
    if (flush_pend) exp_q.delete();
    if (pend_valid) exp_q.push_back(pend);
    flush_pend = 0; pend_valid = 0; new_req = 0; ack_now = 0;
    if (req_active) begin
      check("req_held", mem_req, 1'b1);
      check("req_addr_stable", mem_addr, req_addr_m);
    end else if (mem_req) begin
      new_req = 1;
      check("issue_after_halt_or_redirect", {prev_halt, prev_redirect}, 2'b00);
      check("issue_credit", exp_q.size() < DEPTH, 1'b1);
      check("fetch_addr", mem_addr, fetch_pc);
      req_active = 1; req_epoch = epoch; req_addr_m = fetch_pc;
      fetch_pc = fetch_pc + 1'b1;
      wait_left = $urandom_range(lat_max, lat_min);
    end
    mem_ack = 0; mem_rdata = $urandom;
    if (req_active) begin
      if (wait_left == 0) begin
        mem_ack = 1; mem_rdata = mem_word(mem_addr); ack_now = 1;
      end else wait_left--;
    end
    ifq_ready = ($urandom_range(99, 0) < ready_pct);
    halt      = halt_force || ($urandom_range(99, 0) < halt_pct);
    redirect_valid = 0; redirect_pc = ADDR_W'($urandom);
    if (trg == TRG_NOW || (trg == TRG_ON_ACK && ack_now) ||
        (trg == TRG_ON_NEW && new_req && !ack_now)) begin
      redirect_valid = 1; redirect_pc = trg_pc; trg = TRG_NONE;
    end else if ($urandom_range(99, 0) < redir_pct) begin
      redirect_valid = 1;
    end
    if (redirect_valid) begin
      epoch++; fetch_pc = redirect_pc; flush_pend = 1;
    end
    if (ack_now) begin
      if (req_epoch == epoch) begin
        pend_valid = 1; pend.instr = mem_word(req_addr_m); pend.npc = npc_of(req_addr_m);
      end
      req_active = 0;
    end
    prev_halt = halt; prev_redirect = redirect_valid;
  endtask

  task automatic await_req(output logic [ADDR_W-1:0] addr);
    bit got;
    got = 0; addr = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (new_req) begin got = 1; addr = mem_addr; end
    end
    check("await_req_timeout", got, 1'b1);
  endtask

  task automatic fire();
    for (int i = 0; i < 30 && trg != TRG_NONE; i++) cycle();
    check("trigger_timeout", trg == TRG_NONE, 1'b1);
  endtask

  // Monitor: pops the scoreboard whenever decode takes the head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk1);
      if (mon_en) begin
        check("ifq_valid", ifq_valid, exp_q.size() != 0);
        check("queue_bound", exp_q.size() <= DEPTH, 1'b1);
        if (ifq_valid && ifq_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ifq_instr", ifq_instr, e.instr);
          check("ifq_npc", ifq_npc, e.npc);
          pops++;
        end
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] got, resume;
    int p0;
    rst = 1; redirect_valid = 0; redirect_pc = '0; halt = 0;
    mem_ack = 0; mem_rdata = '0; ifq_ready = 0;
    model_reset();
    repeat (3) @(posedge clk1);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_ifq_valid", ifq_valid, 1'b0);
    check("rst_ifq_instr", ifq_instr, '0);
    check("rst_ifq_npc", ifq_npc, '0);

    // Zero-wait streaming from reset.
    rst = 0; ifq_ready = 1; mon_en = 1;
    cycle();
    check("first_req_cycle1", mem_req, 1'b1);
    cycle();
    check("first_valid_cycle2", ifq_valid, 1'b1);
    check("first_instr", ifq_instr, 32'h100);
    check("first_npc", ifq_npc, 32'd1);
    p0 = pops;
    repeat (20) cycle();
    check("throughput", pops - p0, 20);

    // Backpressure fills the queue and stops requests.
    ready_pct = 0;
    repeat (12) cycle();
    check("full_queue", exp_q.size(), DEPTH);
    check("full_req_low", mem_req, 1'b0);
    resume = fetch_pc; ready_pct = 100;
    await_req(got);
    check("resume_addr", got, resume);
    repeat (6) cycle();

    // Redirect while waiting on a slow ack.
    lat_min = 3; lat_max = 3; trg = TRG_ON_NEW; trg_pc = 10'h020;
    fire();
    cycle();
    check("redir_wait_flushed", ifq_valid, 1'b0);
    await_req(got);
    check("redir_wait_addr", got, 10'h020);
    repeat (10) cycle();

    // Redirect coincident with ack and pop.
    lat_min = 0; lat_max = 0; trg = TRG_ON_ACK; trg_pc = 10'h155;
    fire();
    cycle();
    check("redir_ack_flushed", ifq_valid, 1'b0);
    await_req(got);
    check("redir_ack_addr", got, 10'h155);
    repeat (6) cycle();

    // Halt mid-stream: outstanding request completes, queue drains.
    lat_max = 2; halt_force = 1;
    repeat (15) cycle();
    check("halt_req_low", mem_req, 1'b0);
    check("halt_drained", ifq_valid, 1'b0);
    resume = fetch_pc; halt_force = 0;
    await_req(got);
    check("halt_resume_addr", got, resume);
    repeat (6) cycle();

    // Address wrap at the top of memory.
    lat_max = 0; trg = TRG_NOW; trg_pc = 10'h3FF;
    fire();
    await_req(got);
    check("wrap_first", got, 10'h3FF);
    await_req(got);
    check("wrap_second", got, 10'h000);
    repeat (8) cycle();

    // Random soak.
    lat_min = 0; lat_max = 3; ready_pct = 70; halt_pct = 10; redir_pct = 4;
    repeat (1500) cycle();

    // Reset in the middle of a request drops mem_req immediately.
    halt_pct = 0; redir_pct = 0; lat_min = 3; lat_max = 3;
    await_req(got);
    mon_en = 0;
    rst = 1;
    #1;
    check("midreq_rst_req", mem_req, 1'b0);
    check("midreq_rst_valid", ifq_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Single-clock instruction fetch front end that sits directly upstream of the decode stage. It issues word reads to instruction memory over a req/ack handshake and buffers the returned instructions with their next-PC in a small queue. Decode consumes them over a valid/ready interface. Taken branches redirect the unit: the queue is flushed and fetching restarts at the target. Halt stops new fetches.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- ADDR_W, 10: word-address width. The default matches the 1024-word memory.
- DATA_W, 32: instruction width.

Ports:
- clk1  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- redirect_valid  in  1  taken branch; single-cycle pulse.
- redirect_pc  in  ADDR_W  branch target word address.
- halt  in  1  level; while high, no new memory requests are issued.
- mem_req  out  1  read request; registered.
- mem_addr  out  ADDR_W  read word address; registered.
- mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  read data.
- ifq_valid  out  1  queue head valid.
- ifq_instr  out  DATA_W  head instruction.
- ifq_npc  out  32  head next-PC: (fetch address + 1) mod 2^ADDR_W, zero-extended.
- ifq_ready  in  1  decode accepts the head.

## Operation
- State registers:
  - pc: next fetch address.
  - FSM: IDLE, WAIT, DISCARD, HALTED.
  - queue: DEPTH entries of {instr, npc} with a count.
- Reset values: pc=0, FSM=IDLE, count=0, mem_req=0, mem_addr=0, ifq_valid=0, ifq_instr=0, ifq_npc=0.
- Issue condition: halt=0 and (count + inflight) < DEPTH.
  - inflight is 1 in WAIT, otherwise 0.
  - A pop in the same cycle does not add credit.
- IDLE:
  - If halt=1, go to HALTED.
  - If the issue condition holds: mem_req<=1, mem_addr<=pc, pc<=pc+1, go to WAIT.
- WAIT:
  - mem_req and mem_addr are held stable until mem_ack.
  - On mem_ack, push {mem_rdata, mem_addr+1}.
  - If the issue condition (using the post-push count) still holds, issue the next address back-to-back and stay in WAIT.
  - Otherwise mem_req<=0 and go to IDLE, or to HALTED if halt=1.
- redirect_valid, any state:
  - Queue flushed (count<=0, ifq_valid<=0) and pc<=redirect_pc.
  - Flush wins over a same-cycle push or pop.
  - In WAIT without mem_ack: go to DISCARD. The request stays asserted until ack, and its data is dropped.
  - In WAIT with mem_ack in the same cycle: the ack data is dropped, mem_req<=0, go to IDLE.
  - In DISCARD: pc is updated again and the state stays DISCARD.
  - In HALTED: pc is updated and the state stays HALTED.
- DISCARD: on mem_ack, drop the data, mem_req<=0, go to IDLE.
- HALTED:
  - No requests are issued.
  - The queue still drains through ifq_ready.
  - When halt=0, go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; address 2^ADDR_W−1 is followed by 0.
- Queue full: no push can occur, because the issue condition guarantees space.
- Queue empty: ifq_valid=0; ifq_ready is ignored.

## Timing
- Zero-wait memory (ack in the same cycle as req):
  - First mem_req is high at cycle 1 after rst falls.
  - First ifq_valid is high at cycle 2.
  - Sustained rate is 1 instruction per cycle while decode keeps ifq_ready=1.
- Push-to-visible latency: 1 cycle. Data acked in cycle N appears at the head in cycle N+1 if the queue was empty.
- Redirect in cycle N:
  - With memory idle and zero-wait, the target's mem_req is asserted in cycle N+2 (IDLE re-issue).
  - The target instruction is visible in cycle N+3.
- Pop: an entry leaves on the clk1 edge where ifq_valid&ifq_ready. The next head is visible in the same following cycle.
- Asserting rst mid-request clears mem_req immediately. Memory must discard the request.

## Structure
- Package ipu_pkg holds:
  - the FSM state enum
  - the DATA_W/ADDR_W defaults
  - the queue entry struct {instr, npc}
- One sub-module, ipu_fifo: a synchronous FIFO with flush, count output, DEPTH entries, and registered head outputs.
- The FSM, pc and credit logic sit in the top level.

## Test plan
- Reset release, zero-wait memory returning Mem[a]=a+0x100, ifq_ready=1:
  - mem_addr runs 0,1,2,…
  - ifq_instr runs 0x100,0x101,… with ifq_npc 1,2,…
  - One instruction per cycle from cycle 2.
- ifq_ready=0 with DEPTH=4:
  - Exactly 4 pushes, after which mem_req drops.
  - Raising ifq_ready drains the queue and fetching resumes at address 4.
- Redirect to 0x20 while in WAIT with ack delayed 3 cycles:
  - The stale data is never presented and the queue is empty.
  - Next mem_addr=0x20 and the first ifq_npc is 0x21.
- redirect_valid coincident with mem_ack and ifq_ready:
  - The ack data is dropped and ifq_valid=0 next cycle.
  - pc=redirect_pc.
- halt=1 mid-stream:
  - The outstanding request completes and no new mem_req is issued.
  - The queue drains.
  - halt=0 resumes fetching at the next sequential address.
- redirect_pc=0x3FF (ADDR_W=10): fetches 0x3FF then 0x000, with ifq_npc 0x000 then 0x001.
